// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32 memory-access stage between EX/MEM and MEM/WB.
// Captures one instruction, runs a req/gnt/rvalid data-memory access for
// loads/stores, aligns/extends load data and hands the result downstream.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned H/W accesses skip
// memory and come out flagged on misaligned_o).
module mem_access_stage #(
  parameter int RegAddrWidth     = 4,
  parameter bit ClearDataOnReset = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [31:0]             alu_result_i,
  input  logic [31:0]             store_data_i,
  input  logic [2:0]              funct3_i,
  input  logic [RegAddrWidth-1:0] rd_i,
  input  logic                    MemRead_i,
  input  logic                    MemWrite_i,
  input  logic                    RegWrite_i,
  input  logic                    MemToReg_i,
  output logic                    dmem_req_o,
  input  logic                    dmem_gnt_i,
  output logic                    dmem_we_o,
  output logic [3:0]              dmem_be_o,
  output logic [31:0]             dmem_addr_o,
  output logic [31:0]             dmem_wdata_o,
  input  logic                    dmem_rvalid_i,
  input  logic [31:0]             dmem_rdata_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [31:0]             mem_data_o,
  output logic [31:0]             mem_address_o,
  output logic [RegAddrWidth-1:0] rd_o,
  output logic                    RegWrite_o,
  output logic                    MemToReg_o,
  output logic                    misaligned_o
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_DRAIN} state_t;
  state_t r_state, w_state_d;

  logic r_memread, r_memwrite, r_regwrite, r_memtoreg, r_misaligned;
  logic [31:0]             r_addr, r_sdata, r_mem_data;
  logic [2:0]              r_funct3;
  logic [RegAddrWidth-1:0] r_rd;

  logic [31:0]             w_addr_d, w_sdata_d, w_mem_data_d, w_load, w_wdata;
  logic [2:0]              w_funct3_d;
  logic [RegAddrWidth-1:0] w_rd_d;
  logic [3:0]              w_be;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic w_capture, w_memop_in, w_mis_in, w_load_fire;

  assign w_memop_in = MemRead_i | MemWrite_i;

`ifdef MEM_MISALIGN_TRAP_EN
  // Halfword needs addr[0]==0, word (and anything wider) needs addr[1:0]==0
  assign w_mis_in = w_memop_in &
                    (((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                     (funct3_i[1] & (|alu_result_i[1:0])));
`else
  assign w_mis_in = 1'b0;
`endif

  // Handshake outputs and next state; a capture overrides the per-state choice
  always_comb begin
    w_state_d  = r_state;
    w_capture  = 1'b0;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    dmem_req_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o   = 1'b1;
        w_capture = valid_i & ~flush_i;
      end
      S_REQ: begin
        dmem_req_o = 1'b1;
        if (flush_i)         w_state_d = dmem_gnt_i ? S_DRAIN : S_IDLE;
        else if (dmem_gnt_i) w_state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush_i)            w_state_d = dmem_rvalid_i ? S_IDLE : S_DRAIN;
        else if (dmem_rvalid_i) w_state_d = S_OUT;
      end
      S_OUT: begin
        valid_o = 1'b1;
        ready_o = ready_i;
        if (flush_i) w_state_d = S_IDLE;
        else if (ready_i) begin
          w_state_d = S_IDLE;
          w_capture = valid_i;
        end
      end
      S_DRAIN: if (dmem_rvalid_i) w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
    if (w_capture) w_state_d = (w_memop_in & ~w_mis_in) ? S_REQ : S_OUT;
  end

  assign w_load_fire = (r_state == S_WAIT) & dmem_rvalid_i & ~flush_i & r_memread;

  // Byte enables and lane-replicated store data from the held instruction
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_sdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_sdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata = {2{r_sdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and sign/zero extension of the returned word
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = dmem_rdata_i[7:0];
      2'd1:    w_byte = dmem_rdata_i[15:8];
      2'd2:    w_byte = dmem_rdata_i[23:16];
      default: w_byte = dmem_rdata_i[31:24];
    endcase
    w_half = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = dmem_rdata_i;
    endcase
  end

  // Next values of the data registers (captured fields and load result)
  always_comb begin
    w_addr_d     = r_addr;
    w_sdata_d    = r_sdata;
    w_funct3_d   = r_funct3;
    w_rd_d       = r_rd;
    w_mem_data_d = r_mem_data;
    if (w_capture) begin
      w_addr_d     = alu_result_i;
      w_sdata_d    = store_data_i;
      w_funct3_d   = funct3_i;
      w_rd_d       = rd_i;
      w_mem_data_d = '0;
    end else if (w_load_fire) begin
      w_mem_data_d = w_load;
    end
  end

  // State and control bits always reset; misaligned flag drops when OUT is left
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state      <= S_IDLE;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_capture) begin
        r_memread    <= MemRead_i;
        r_memwrite   <= MemWrite_i;
        r_regwrite   <= RegWrite_i & ~w_mis_in;
        r_memtoreg   <= MemToReg_i;
        r_misaligned <= w_mis_in;
      end else if ((r_state == S_OUT) && (flush_i || ready_i)) begin
        r_misaligned <= 1'b0;
      end
    end
  end

  // Data registers: reset only when ClearDataOnReset is set
  generate
    if (ClearDataOnReset) begin : g_data_rst
      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          r_addr     <= '0;
          r_sdata    <= '0;
          r_funct3   <= '0;
          r_rd       <= '0;
          r_mem_data <= '0;
        end else begin
          r_addr     <= w_addr_d;
          r_sdata    <= w_sdata_d;
          r_funct3   <= w_funct3_d;
          r_rd       <= w_rd_d;
          r_mem_data <= w_mem_data_d;
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk_i) begin
        r_addr     <= w_addr_d;
        r_sdata    <= w_sdata_d;
        r_funct3   <= w_funct3_d;
        r_rd       <= w_rd_d;
        r_mem_data <= w_mem_data_d;
      end
    end
  endgenerate

  assign dmem_we_o     = (r_state == S_REQ) & r_memwrite;
  assign dmem_be_o     = (r_state == S_REQ) ? w_be : 4'b0000;
  assign dmem_addr_o   = {r_addr[31:2], 2'b00};
  assign dmem_wdata_o  = w_wdata;
  assign mem_data_o    = r_mem_data;
  assign mem_address_o = r_addr;
  assign rd_o          = r_rd;
  assign RegWrite_o    = r_regwrite;
  assign MemToReg_o    = r_memtoreg;
  assign misaligned_o  = r_misaligned;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the RV32 pipeline; sits between the EX/MEM register and the MEM/WB register (MW_pipeline).
- Accepts one instruction per valid/ready handshake and issues load/store requests to the data memory over a req/gnt/rvalid interface.
- Aligns and extends load data, then presents the result with a valid/ready handshake to the MEM/WB register.
- Non-memory instructions pass through without touching memory.

Parameters:
- RegAddrWidth, 4, width of the destination register index rd.
- ClearDataOnReset, 1, if 1, output data registers are cleared on reset; if 0, only state and control bits are cleared.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  squashes the instruction held in this stage.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept an instruction.
- alu_result_i  in  32  effective address, or ALU result for non-memory instructions.
- store_data_i  in  32  rs2 value for stores.
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rd_i  in  RegAddrWidth  destination register.
- MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i  in  1 each  control bits.
- dmem_req_o  out  1  memory request.
- dmem_gnt_i  in  1  request accepted.
- dmem_we_o  out  1  write enable.
- dmem_be_o  out  4  byte enables.
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata_o  out  32  lane-shifted store data.
- dmem_rvalid_i  in  1  read/write response valid.
- dmem_rdata_i  in  32  read data word.
- valid_o  out  1  result valid to MEM/WB.
- ready_i  in  1  MEM/WB can accept.
- mem_data_o  out  32  extended load data; 0 for non-loads.
- mem_address_o  out  32  alu_result passthrough.
- rd_o, RegWrite_o, MemToReg_o  out  -  passthrough.
- misaligned_o  out  1  misaligned access flag; only meaningful with the optional feature, tied 0 otherwise.

Behaviour:
- Reset:
  - State returns to IDLE.
  - valid_o, dmem_req_o, dmem_we_o, misaligned_o and RegWrite_o are 0.
  - dmem_be_o is 0.
  - With ClearDataOnReset=1, all data outputs are 0.
  - Reset asserted mid-transaction abandons it immediately; any later rvalid is ignored.
- States:
  - IDLE: ready_o=1. On valid_i && !flush_i, capture all inputs. If MemRead_i|MemWrite_i, go to REQ; else go to OUT.
  - REQ: dmem_req_o=1 with address, we, be and wdata held stable until dmem_gnt_i. On gnt, go to WAIT.
  - WAIT: wait for dmem_rvalid_i. On rvalid, a load latches the extended data; go to OUT.
  - OUT: valid_o=1 and ready_o=ready_i. On ready_i: if valid_i, capture the next instruction and branch as in IDLE; else go to IDLE.
  - DRAIN: ready_o=0; discard the pending response; on rvalid go to IDLE.
- Latency:
  - Non-memory instruction: valid_o is 1 cycle after capture.
  - Memory instruction: valid_o is 1 cycle after rvalid.
  - Best case with gnt in the same cycle as req and rvalid the next cycle: 3 cycles from capture.
- Byte lanes:
  - Byte access: be = 0001 << addr[1:0].
  - Halfword access: be = 0011 << {addr[1],1'b0}.
  - Word access: be = 1111.
  - wdata replicates the byte or halfword across all lanes.
- Load extraction: select the lane by addr[1:0]. B/H are sign-extended; BU/HU are zero-extended.
- Flush:
  - IDLE or OUT: held instruction dropped, go to IDLE, valid_o deasserts next cycle; a same-cycle valid_i is not captured.
  - REQ before gnt: request withdrawn, go to IDLE.
  - REQ with gnt in the same cycle: go to DRAIN.
  - WAIT: go to DRAIN, or to IDLE if rvalid arrives in the same cycle.
  - A granted store still commits in memory; only its pipeline result is squashed.
- rvalid arriving in IDLE, REQ or OUT is ignored.
- Without the optional feature:
  - Halfword access ignores addr[0].
  - Word access ignores addr[1:0].

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, issues no memory request.
  - The stage goes directly to OUT with misaligned_o=1, RegWrite_o=0 and mem_data_o=0.
  - misaligned_o clears when the instruction leaves OUT.
- Not defined: misaligned_o is constant 0 and the address bits are ignored as described in Behaviour.

Test Plan:
- LW at 0x100, gnt in the same cycle, rdata=0xDEADBEEF the next cycle -> dmem_be_o=1111, dmem_addr_o=0x100; mem_data_o=0xDEADBEEF with valid_o=1 three cycles after capture.
- LB at 0x103, rdata=0x80112233 -> be=1000, mem_data_o=0xFFFFFF80. The same access as LBU -> mem_data_o=0x00000080.
- SH at 0x202, store_data=0x0000ABCD -> dmem_we_o=1, be=1100, wdata=0xABCDABCD; on ready_i, RegWrite_o=0 and mem_data_o=0.
- ADD result 0x55 with rd=5, ready_i=0 for 3 cycles -> no dmem_req_o; valid_o and outputs held stable (mem_address_o=0x55, rd_o=5) until ready_i, with back-to-back accept on that cycle.
- LW granted, flush_i in WAIT, rvalid 2 cycles later -> DRAIN; no valid_o; ready_o=0 until rvalid, then IDLE.
- With MEM_MISALIGN_TRAP_EN, LW at 0x102 -> no dmem_req_o, valid_o=1 next cycle, misaligned_o=1, RegWrite_o=0.
